// File: rtl/crc_sched_pkg.sv
// Shared types and helpers for the multi-channel CRC scheduler.
// Mode encodings match the CRC_*_MODE values used by the crc register block.
package crc_sched_pkg;

  localparam logic [1:0] CRC8_07_MODE    = 2'd0;
  localparam logic [1:0] CRC16_1021_MODE = 2'd1;
  localparam logic [1:0] CRC16_8005_MODE = 2'd2;
  localparam logic [1:0] CRC32_MODE      = 2'd3;

  typedef enum logic [1:0] {IDLE, CALC, RESULT} state_t;

  typedef struct packed {
    logic [31:0] crc;
    logic [1:0]  mode;
    logic        revin;
    logic        revout;
    logic [31:0] xorv;
  } ctx_t;

  function automatic logic [31:0] width_mask(input logic [1:0] mode);
    case (mode)
      CRC8_07_MODE: return 32'h0000_00FF;
      CRC32_MODE:   return 32'hFFFF_FFFF;
      default:      return 32'h0000_FFFF;
    endcase
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Full 32-bit reversal, then shift the reversed low field back down.
  function automatic logic [31:0] rev_width(input logic [31:0] v, input logic [1:0] mode);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    case (mode)
      CRC8_07_MODE: return r >> 24;
      CRC32_MODE:   return r;
      default:      return r >> 16;
    endcase
  endfunction

  // MSB-first byte update; top selects the CRC's most significant bit.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b,
                                           input logic [31:0] poly, input logic [31:0] top);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = ((c & top) != 32'h0) ^ b[i];
      c  = (c << 1) ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_1021.sv
// CRC-16 (poly 0x1021) single-byte combinational update.
module crc16_1021
  import crc_sched_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  assign crc_o = 16'(crc_byte({16'h0, crc_i}, data_i, 32'h0000_1021, 32'h0000_8000));
endmodule

// File: rtl/crc16_8005.sv
// CRC-16 (poly 0x8005) single-byte combinational update.
module crc16_8005
  import crc_sched_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  assign crc_o = 16'(crc_byte({16'h0, crc_i}, data_i, 32'h0000_8005, 32'h0000_8000));
endmodule

// File: rtl/crc32_04c11db7.sv
// CRC-32 (poly 0x04C11DB7) single-byte combinational update.
module crc32_04c11db7
  import crc_sched_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  assign crc_o = crc_byte(crc_i, data_i, 32'h04C1_1DB7, 32'h8000_0000);
endmodule

// File: rtl/crc8_07.sv
// CRC-8 (poly 0x07) single-byte combinational update.
module crc8_07
  import crc_sched_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);
  assign crc_o = 8'(crc_byte({24'h0, crc_i}, data_i, 32'h0000_0007, 32'h0000_0080));
endmodule

// File: rtl/crc_sched_rr_arb.sv
// Round-robin arbiter: searches from the channel after the last grant.
// The pointer only moves when a grant is actually issued.
module crc_rr_arb #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] ptr_q, ptr_d, cand;
  logic         found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    ptr_d = ptr_q;
    cand  = '0;
    found = 1'b0;
    if (en_i) begin
      for (int i = 1; i <= N; i++) begin
        cand = W'((int'(ptr_q) + i) % N);
        if (!found && req_i[cand]) begin
          found       = 1'b1;
          gnt_o[cand] = 1'b1;
          idx_o       = cand;
          ptr_d       = cand;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= W'(N - 1);
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/crc_sched.sv
// Shares one byte-serial CRC datapath between CH_NUM requesters, keeping a
// per-channel running context so frames interleave at word granularity.
module crc_sched
  import crc_sched_pkg::*;
#(
  parameter  int CH_NUM   = 4,
  localparam int CH_WIDTH = $clog2(CH_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CH_NUM-1:0]     req_valid_i,
  output logic [CH_NUM-1:0]     req_ready_o,
  input  logic [CH_NUM*32-1:0]  req_data_i,
  input  logic [CH_NUM*2-1:0]   req_size_i,
  input  logic [CH_NUM-1:0]     req_first_i,
  input  logic [CH_NUM-1:0]     req_last_i,
  input  logic [CH_NUM*2-1:0]   cfg_mode_i,
  input  logic [CH_NUM-1:0]     cfg_revin_i,
  input  logic [CH_NUM-1:0]     cfg_revout_i,
  input  logic [CH_NUM*32-1:0]  cfg_init_i,
  input  logic [CH_NUM*32-1:0]  cfg_xorv_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [CH_WIDTH-1:0]   res_ch_o,
  output logic [31:0]           res_crc_o,
  output logic                  busy_o,
  output state_t                state_o
);
  // Handshake: a word moves when req_valid_i[c] & req_ready_o[c] at a rising
  // edge; a result moves when res_valid_o & res_ready_i at a rising edge.
  state_t              state_q, state_d;
  logic [CH_WIDTH-1:0] ch_q, ch_d, res_ch_q, res_ch_d, gnt_idx;
  logic [31:0]         data_q, data_d, res_crc_q, res_crc_d;
  logic [1:0]          size_q, size_d, cnt_q, cnt_d;
  logic                last_q, last_d, res_valid_q, res_valid_d, busy_q, busy_d;
  ctx_t                ctx_q [CH_NUM];
  ctx_t                ctx_d [CH_NUM];
  logic [CH_NUM-1:0]   gnt;
  ctx_t                cur;
  logic [7:0]          byte_in, c8;
  logic [15:0]         c16a, c16b;
  logic [31:0]         c32, crc_new, res_val;

  crc_rr_arb #(.N(CH_NUM)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q == IDLE && !rst_i),
    .req_i (req_valid_i),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );
  assign req_ready_o = gnt;

  assign cur     = ctx_q[ch_q];
  assign byte_in = cur.revin ? rev8(data_q[31:24]) : data_q[31:24];

  crc8_07        u_c8   (.crc_i(cur.crc[7:0]),  .data_i(byte_in), .crc_o(c8));
  crc16_1021     u_c16a (.crc_i(cur.crc[15:0]), .data_i(byte_in), .crc_o(c16a));
  crc16_8005     u_c16b (.crc_i(cur.crc[15:0]), .data_i(byte_in), .crc_o(c16b));
  crc32_04c11db7 u_c32  (.crc_i(cur.crc),       .data_i(byte_in), .crc_o(c32));

  always_comb begin
    case (cur.mode)
      CRC8_07_MODE:    crc_new = {24'h0, c8};
      CRC16_1021_MODE: crc_new = {16'h0, c16a};
      CRC16_8005_MODE: crc_new = {16'h0, c16b};
      default:         crc_new = c32;
    endcase
    res_val = ((cur.revout ? rev_width(crc_new, cur.mode) : crc_new) ^ cur.xorv)
              & width_mask(cur.mode);
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    data_d      = data_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_crc_d   = res_crc_q;
    ctx_d       = ctx_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          ch_d    = gnt_idx;
          cnt_d   = 2'd0;
          state_d = CALC;
          for (int c = 0; c < CH_NUM; c++) begin
            if (gnt[c]) begin
              data_d = req_data_i[32*c +: 32];
              size_d = req_size_i[2*c +: 2];
              last_d = req_last_i[c];
              // A first word restarts the context, dropping any open frame.
              if (req_first_i[c]) begin
                ctx_d[c].crc    = cfg_init_i[32*c +: 32] & width_mask(cfg_mode_i[2*c +: 2]);
                ctx_d[c].mode   = cfg_mode_i[2*c +: 2];
                ctx_d[c].revin  = cfg_revin_i[c];
                ctx_d[c].revout = cfg_revout_i[c];
                ctx_d[c].xorv   = cfg_xorv_i[32*c +: 32];
              end
            end
          end
        end
      end
      CALC: begin
        ctx_d[ch_q].crc = crc_new;
        data_d          = {data_q[23:0], 8'h00};
        cnt_d           = cnt_q + 2'd1;
        if (cnt_q == size_q) begin
          if (last_q) begin
            state_d     = RESULT;
            res_valid_d = 1'b1;
            res_ch_d    = ch_q;
            res_crc_d   = res_val;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RESULT: begin
        if (res_ready_i) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      data_q      <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_crc_q   <= '0;
      busy_q      <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) ctx_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_crc_q   <= res_crc_d;
      busy_q      <= busy_d;
      ctx_q       <= ctx_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_ch_o    = res_ch_q;
  assign res_crc_o   = res_crc_q;
  assign busy_o      = busy_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_crc_sched.sv
// Self-checking bench for crc_sched: scenario tasks plus a result scoreboard.
`timescale 1ns/1ps
module tb_crc_sched;
  import crc_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_first, req_last, cfg_revin, cfg_revout;
  logic [127:0] req_data, cfg_init, cfg_xorv;
  logic [7:0]   req_size, cfg_mode;
  logic         res_ready;
  logic [3:0]   req_ready_o;
  logic         res_valid_o, busy_o;
  logic [1:0]   res_ch_o;
  logic [31:0]  res_crc_o;
  state_t       state_o;

  logic [33:0]  exp_q[$];
  int           grant_q[$];
  bit           log_en = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  crc_sched #(.CH_NUM(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_data_i(req_data),
    .req_size_i(req_size), .req_first_i(req_first), .req_last_i(req_last),
    .cfg_mode_i(cfg_mode), .cfg_revin_i(cfg_revin), .cfg_revout_i(cfg_revout),
    .cfg_init_i(cfg_init), .cfg_xorv_i(cfg_xorv),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready), .res_ch_o(res_ch_o),
    .res_crc_o(res_crc_o), .busy_o(busy_o), .state_o(state_o)
  );

  // Scoreboard: pop one expected {ch, crc} per result handshake.
  always @(negedge clk) begin
    if (res_valid_o && res_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got ch %0d crc %h, required no result", res_ch_o, res_crc_o);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({res_ch_o, res_crc_o} !== e) begin
          n_err++;
          $display("FAIL result: got ch %0d crc %h, required ch %0d crc %h",
                   res_ch_o, res_crc_o, e[33:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (log_en)
      for (int c = 0; c < 4; c++)
        if (req_valid[c] && req_ready_o[c]) grant_q.push_back(c);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input int ch, input logic [1:0] mode, input logic ri, input logic ro,
                         input logic [31:0] init, input logic [31:0] xorv);
    cfg_mode[2*ch +: 2]  = mode;
    cfg_revin[ch]        = ri;
    cfg_revout[ch]       = ro;
    cfg_init[32*ch +: 32] = init;
    cfg_xorv[32*ch +: 32] = xorv;
  endtask

  // Call only just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input int ch, input logic [31:0] d, input logic [1:0] sz,
                           input logic f, input logic l, input logic [31:0] exp_crc);
    int n;
    req_data[32*ch +: 32] = d;
    req_size[2*ch +: 2]   = sz;
    req_first[ch]         = f;
    req_last[ch]          = l;
    req_valid[ch]         = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready_o[ch] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o[ch]) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout ch%0d: ready stayed 0, required 1", ch);
      req_valid[ch] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid[ch] = 1'b0;
      if (l) exp_q.push_back({2'(ch), exp_crc});
    end
  endtask

  task automatic send_frame(input int ch, input logic [31:0] exp_crc);
    send_word(ch, 32'h3132_3334, 2'd3, 1'b1, 1'b0, 32'h0);
    send_word(ch, 32'h3536_3738, 2'd3, 1'b0, 1'b0, 32'h0);
    send_word(ch, 32'h3900_0000, 2'd0, 1'b0, 1'b1, exp_crc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready_o !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b, required 0000", req_ready_o); end
    n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", res_valid_o); end
    n_cmp++; if (res_ch_o !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d, required 0", res_ch_o); end
    n_cmp++; if (res_crc_o !== 32'h0) begin n_err++; $display("FAIL reset_crc: got %h, required 0", res_crc_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    n_cmp++; if (state_o !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required IDLE", state_o); end
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_channels();
    set_cfg(0, CRC32_MODE, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    set_cfg(1, CRC32_MODE, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_cfg(2, CRC16_1021_MODE, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0);
    set_cfg(3, CRC8_07_MODE, 1'b0, 1'b0, 32'h0, 32'h0);
    send_frame(0, 32'h0376_E6E7);
    send_frame(1, 32'hCBF4_3926);
    send_frame(2, 32'h0000_29B1);
    send_frame(3, 32'h0000_00F4);
    wait_drain();
  endtask

  task automatic test_first_last();
    int n;
    set_cfg(1, CRC8_07_MODE, 1'b0, 1'b0, 32'h0, 32'h0);
    send_word(1, 32'h3100_0000, 2'd0, 1'b1, 1'b1, 32'h0000_0097);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid_o && n < 20);
    n_cmp++; if (n != 2) begin n_err++; $display("FAIL result_latency: got %0d cycles, required 2", n); end
    wait_drain();
  endtask

  task automatic test_cfg_change();
    set_cfg(0, CRC32_MODE, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    send_word(0, 32'h3132_3334, 2'd3, 1'b1, 1'b0, 32'h0);
    set_cfg(0, CRC8_07_MODE, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    send_word(0, 32'h3536_3738, 2'd3, 1'b0, 1'b0, 32'h0);
    send_word(0, 32'h3900_0000, 2'd0, 1'b0, 1'b1, 32'h0376_E6E7);
    wait_drain();
  endtask

  task automatic test_restart();
    set_cfg(3, CRC8_07_MODE, 1'b0, 1'b0, 32'h0, 32'h0);
    send_word(3, 32'h3132_3334, 2'd3, 1'b1, 1'b0, 32'h0);
    send_frame(3, 32'h0000_00F4);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n;
    apply_reset();
    for (int c = 0; c < 4; c++) set_cfg(c, CRC16_8005_MODE, 1'b0, 1'b0, 32'h0, 32'h0);
    grant_q.delete();
    log_en = 1'b1;
    fork
      send_frame(0, 32'h0000_FEE8);
      send_frame(1, 32'h0000_FEE8);
      send_frame(2, 32'h0000_FEE8);
      send_frame(3, 32'h0000_FEE8);
    join
    wait_drain();
    log_en = 1'b0;
    n_cmp++;
    if (grant_q.size() != 12) begin n_err++; $display("FAIL grant_count: got %0d, required 12", grant_q.size()); end
    n = (grant_q.size() < 12) ? grant_q.size() : 12;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (grant_q[i] != i % 4) begin n_err++; $display("FAIL grant_order[%0d]: got ch %0d, required ch %0d", i, grant_q[i], i % 4); end
    end
  endtask

  task automatic test_result_hold();
    set_cfg(3, CRC8_07_MODE, 1'b0, 1'b0, 32'h0, 32'h0);
    set_cfg(0, CRC8_07_MODE, 1'b0, 1'b0, 32'h0, 32'h0);
    res_ready = 1'b0;
    send_frame(3, 32'h0000_00F4);
    fork
      send_word(0, 32'h3100_0000, 2'd0, 1'b1, 1'b1, 32'h0000_0097);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid_o && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 10; i++) begin
          n_cmp++;
          if (res_valid_o !== 1'b1 || res_ch_o !== 2'd3 || res_crc_o !== 32'hF4 || req_ready_o !== 4'b0) begin
            n_err++;
            $display("FAIL hold[%0d]: got valid %b ch %0d crc %h ready %b, required valid 1 ch 3 crc 000000f4 ready 0000",
                     i, res_valid_o, res_ch_o, res_crc_o, req_ready_o);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b, required 0", res_valid_o); end
        n_cmp++; if (busy_o !== 1'b0 || state_o !== IDLE) begin n_err++; $display("FAIL release_idle: got busy %b state %0d, required 0 IDLE", busy_o, state_o); end
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL release_grant: got %b, required 0001", req_ready_o); end
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid();
    set_cfg(2, CRC16_1021_MODE, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0);
    send_word(2, 32'h3132_3334, 2'd3, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_o !== IDLE || busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_state: got state %0d busy %b, required IDLE 0", state_o, busy_o); end
    n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, required 0", res_valid_o); end
    n_cmp++; if (res_crc_o !== 32'h0 || res_ch_o !== 2'd0) begin n_err++; $display("FAIL midrst_result: got ch %0d crc %h, required 0 0", res_ch_o, res_crc_o); end
    n_cmp++; if (req_ready_o !== 4'b0) begin n_err++; $display("FAIL midrst_ready: got %b, required 0000", req_ready_o); end
    @(posedge clk);
    #1;
    grant_q.delete();
    log_en = 1'b1;
    fork
      send_frame(2, 32'h0000_29B1);
      send_word(0, 32'h3100_0000, 2'd0, 1'b1, 1'b1, 32'h0000_0097);
    join
    wait_drain();
    log_en = 1'b0;
    n_cmp++;
    if (grant_q.size() == 0 || grant_q[0] != 0) begin
      n_err++;
      $display("FAIL simultaneous_grant: got ch %0d, required ch 0", (grant_q.size() == 0) ? -1 : grant_q[0]);
    end
    // Channel 1 has no frame since reset: its cfg must be ignored.
    set_cfg(1, CRC32_MODE, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_word(1, 32'h3100_0000, 2'd0, 1'b0, 1'b1, 32'h0000_0097);
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_first = '0; req_last = '0; req_data = '0; req_size = '0;
    cfg_mode = '0; cfg_revin = '0; cfg_revout = '0; cfg_init = '0; cfg_xorv = '0;
    res_ready = 1'b1;
    test_reset();
    test_single_channels();
    test_first_last();
    test_cfg_change();
    test_restart();
    test_back_to_back();
    test_result_hold();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/crc_sched.md
Name: crc_sched

Overview:
- Multi-channel scheduler that shares one byte-serial CRC datapath between CH_NUM independent requesters. The datapath is built from the existing crc8_07, crc16_1021, crc16_8005 and crc32_04c11db7 combinational units.
- Grants one channel at a time with round-robin arbitration and feeds the granted word into the datapath one byte per cycle.
- Keeps a per-channel running CRC context, so frames from different channels interleave at word granularity.
- On each channel's last word, delivers the finished CRC through a valid/ready result port. Sits between DMA/stream producers and the crc register block.

Parameters:
- CH_NUM, 4, number of requester channels (2..8).
- CH_WIDTH, $clog2(CH_NUM), channel index width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous and active-high.
- req_valid_i  in  CH_NUM  per-channel word valid.
- req_ready_o  out  CH_NUM  per-channel accept. One-hot or zero.
- req_data_i  in  CH_NUM*32  word, left-aligned; byte [31:24] is processed first.
- req_size_i  in  CH_NUM*2  valid bytes minus 1. 0 means 1 byte, 3 means 4 bytes.
- req_first_i  in  CH_NUM  word starts a frame: load init, sample config.
- req_last_i  in  CH_NUM  word ends a frame: emit result.
- cfg_mode_i  in  CH_NUM*2  polynomial select: 0 CRC8_07, 1 CRC16_1021, 2 CRC16_8005, 3 CRC32.
- cfg_revin_i  in  CH_NUM  reverse bits within each input byte.
- cfg_revout_i  in  CH_NUM  reverse the result over the CRC width.
- cfg_init_i  in  CH_NUM*32  init value; the low bits are used, per width.
- cfg_xorv_i  in  CH_NUM*32  final XOR value; the low bits are used.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accept.
- res_ch_o  out  CH_WIDTH  channel the result belongs to.
- res_crc_o  out  32  result, right-aligned, upper bits zero.
- busy_o  out  1  FSM is not in IDLE.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - req_ready_o=0, res_valid_o=0, res_ch_o=0, res_crc_o=0, busy_o=0.
  - All contexts (crc, mode, revin, revout, xorv) are cleared.
  - RR pointer is set so channel 0 has highest priority.
  - Reset mid-operation abandons the word in flight and any pending result. Nothing is emitted.
- FSM: IDLE -> CALC -> (last ? RESULT : IDLE); RESULT -> IDLE when res_ready_i=1.
- IDLE arbitration:
  - Round-robin over req_valid_i, starting at the channel after the last granted one.
  - req_ready_o[g] is driven combinationally in the same cycle. The word transfers when valid&ready.
  - The accepted word, size, first and last are latched.
  - If first=1, the channel context loads init[width-1:0] and samples mode, revin, revout and xorv. These stay held for the whole frame.
  - Cfg changes mid-frame are ignored.
- CALC:
  - Processes one byte per cycle: byte k is data[31-8k -: 8], for k=0..size.
  - Each byte is bit-reversed first if the context revin=1.
  - The context CRC updates every cycle through the unit selected by the context mode. Only that width is meaningful.
  - CALC lasts size+1 cycles. After the final byte: go to RESULT if last=1, otherwise IDLE.
- Latency:
  - Accept to next possible accept (non-last word): size+2 cycles.
  - Accept to res_valid_o (last word): size+2 cycles.
- RESULT:
  - res_crc_o = (revout ? reverse over width : crc) ^ xorv[width-1:0], zero-extended.
  - res_valid_o is held, with stable data and channel, until res_ready_i. No other channel is granted while in RESULT.
  - The context CRC keeps its value until the next first word.
- Boundary conditions:
  - first&last on one word: a complete single-word frame.
  - A word with first=0 on a never-started channel uses the reset context (crc=0, mode 0).
  - A new first on an unfinished frame discards the old frame silently.
  - res_ready_i asserted while res_valid_o=0 is ignored.
  - When there are no requests, the RR pointer does not move.

Decomposition:
- Package crc_sched_pkg holds:
  - Mode encodings, matching the existing CRC_*_MODE values.
  - The FSM state enum {IDLE, CALC, RESULT}.
  - The context struct: crc[31:0], mode, revin, revout, xorv.
  - Functions: byte bit-reversal, and width-dependent result reverse.
- One sub-module, crc_rr_arb: parameterized round-robin arbiter with a grant-enable, giving a one-hot grant plus index. The CRC units are instantiated directly.

Test Plan:
- ch0, CRC32 (init FFFFFFFF, xorv 0, no reflection), "123456789" sent as 31323334 (size3, first), 35363738 (size3), 39 in [31:24] (size0, last) -> res_ch=0, res_crc=0376E6E7.
- ch1, CRC32 with revin=revout=1, init and xorv FFFFFFFF, same words -> CBF43926. ch2, CRC16_1021, init FFFF, same words -> 000029B1. ch3, CRC8, init 0 -> 000000F4.
- All four channels valid continuously, each running a 3-word "123456789" frame (CRC16_8005, init 0) -> grants rotate 0,1,2,3,0,...; each result is 0000FEE8; per-channel results are correct despite interleaving.
- Hold res_ready_i=0 for 10 cycles during RESULT -> res_valid_o and data stay stable and no req_ready_o asserts; release -> accept, then IDLE the next cycle.
- Assert rst_i during CALC of ch2 -> the next cycle shows all outputs 0 and state IDLE. A fresh ch2 frame then gives the correct CRC, and channel 0 wins a simultaneous request.
- Change cfg_mode_i of ch0 mid-frame -> the result still matches the mode sampled on the first word.
